count_sequencer: RTL and testbench

//  Run controller and position register for the 0..MAX_COUNT display counter on the 1 Hz domain.

---
 rtl/count_sequencer.sv | 144 ++++++++++++++
 tb/tb_count_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Run controller and position register for the 0..MAX_COUNT display counter (1 Hz domain).
// Sequences up/down/bounce runs of bounded or unbounded length with pause/resume and an end-of-run pulse.
//
//  state | meaning
//  ------+--------------------------------------------------
//  IDLE  | no run active; count and dir hold
//  RUN   | one step per clk_1Hz edge according to mode_q
//  PAUSE | run suspended; count, dir, steps_left, mode_q hold
//  DONE  | final step taken; done high for one period
module count_sequencer #(
    parameter int MAX_COUNT = 5,
    parameter int CNT_W     = 3,
    parameter int RUN_W     = 4
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [RUN_W-1:0] run_len,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    state_t             state_q;
    logic [RUN_W-1:0]   steps_left;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   step_count;
    logic               step_dir;

    // Next position if a step is taken this edge; out-of-range counts recover to 0.
    always_comb begin
        step_count = count;
        step_dir   = dir;
        case (mode_q)
            2'b00: begin
                step_count = (count >= MAX_C) ? '0 : count + CNT_ONE;
            end
            2'b01: begin
                if (count > MAX_C)
                    step_count = '0;
                else if (count == '0)
                    step_count = MAX_C;
                else
                    step_count = count - CNT_ONE;
            end
            2'b10: begin
                if (count > MAX_C) begin
                    step_count = '0;
                    step_dir   = 1'b0;
                end else if (!dir) begin
                    if (count == MAX_C) begin
                        step_count = MAX_C - CNT_ONE;
                        step_dir   = 1'b1;
                    end else begin
                        step_count = count + CNT_ONE;
                    end
                end else begin
                    if (count == '0) begin
                        step_count = CNT_ONE;
                        step_dir   = 1'b0;
                    end else begin
                        step_count = count - CNT_ONE;
                    end
                end
            end
            default: begin
                step_count = count;
                step_dir   = dir;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count      <= '0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            mode_q     <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop && mode != 2'b11) begin
                        state_q    <= S_RUN;
                        mode_q     <= mode;
                        steps_left <= run_len;
                        dir        <= (mode == 2'b01);
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_PAUSE;
                    end else begin
                        count <= step_count;
                        dir   <= step_dir;
                        // A zero length latched at start means the run never ends on its own.
                        if (steps_left != '0) begin
                            steps_left <= steps_left - RUN_ONE;
                            if (steps_left == RUN_ONE) begin
                                state_q <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start && !stop)
                        state_q <= S_RUN;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed literal scenarios plus randomized runs
// compared every cycle against a behavioural model.
module tb_count_sequencer;

    localparam int MAXC  = 5;
    localparam int CNT_W = 3;
    localparam int RUN_W = 4;

    logic             clk_1Hz;
    logic             reset;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [RUN_W-1:0] run_len;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    // behavioural model: 0 idle, 1 run, 2 pause, 3 done
    int m_state, m_count, m_dir, m_left, m_mode;

    count_sequencer #(.MAX_COUNT(MAXC), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .run_len (run_len),
        .count   (count),
        .dir     (dir),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    initial begin
        clk_1Hz = 1'b0;
        forever #5 clk_1Hz = ~clk_1Hz;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_count = 0; m_dir = 0; m_left = 0; m_mode = 0;
    endtask

    task automatic model_step();
        case (m_state)
            0: if (start && !stop && mode != 2'b11) begin
                m_state = 1;
                m_mode  = int'(mode);
                m_left  = int'(run_len);
                m_dir   = (mode == 2'b01) ? 1 : 0;
            end
            1: if (stop) begin
                m_state = 2;
            end else begin
                if (m_mode == 0) begin
                    m_count = (m_count + 1) % (MAXC + 1);
                end else if (m_mode == 1) begin
                    m_count = (m_count + MAXC) % (MAXC + 1);
                end else begin
                    if (m_dir == 0 && m_count == MAXC) m_dir = 1;
                    else if (m_dir == 1 && m_count == 0) m_dir = 0;
                    m_count = m_count + ((m_dir == 0) ? 1 : -1);
                end
                if (m_left > 0) begin
                    if (m_left == 1) m_state = 3;
                    m_left = m_left - 1;
                end
            end
            2: if (start && !stop) m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_model();
        int e_busy, e_done;
        e_busy = (m_state == 1 || m_state == 2) ? 1 : 0;
        e_done = (m_state == 3) ? 1 : 0;
        checks++;
        if (int'(count) != m_count || int'(dir) != m_dir || int'(busy) != e_busy ||
            int'(done) != e_done || int'(state) != m_state) begin
            errors++;
            $display("FAIL model t=%0t: got count=%0d dir=%0d busy=%0d done=%0d state=%0d required count=%0d dir=%0d busy=%0d done=%0d state=%0d",
                     $time, count, dir, busy, done, state, m_count, m_dir, e_busy, e_done, m_state);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // One clock period: model advances on the rising edge, outputs compared after the falling edge.
    task automatic tick();
        @(posedge clk_1Hz);
        if (!reset) model_step();
        @(negedge clk_1Hz);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_up[7]   = '{1, 2, 3, 4, 5, 0, 1};
        int exp_bc[11]  = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        int exp_bd[11]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        int exp_p[3]    = '{3, 4, 5};

        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; run_len = '0;
        model_reset();
        #1;
        check_lit("reset_count", int'(count), 0);
        check_lit("reset_state", int'(state), 0);
        check_lit("reset_busy", int'(busy), 0);
        do_reset();

        // continuous up count with wrap
        mode = 2'b00; run_len = 0; start = 1'b1;
        tick();
        start = 1'b0;
        check_lit("t1_busy", int'(busy), 1);
        check_lit("t1_count0", int'(count), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_lit("t1_count", int'(count), exp_up[i]);
            check_lit("t1_done", int'(done), 0);
        end

        // bounded down run from 0
        do_reset();
        mode = 2'b01; run_len = 3; start = 1'b1;
        tick();
        start = 1'b0;
        check_lit("t2_dir", int'(dir), 1);
        tick(); check_lit("t2_c5", int'(count), 5);
        tick(); check_lit("t2_c4", int'(count), 4);
        tick(); check_lit("t2_c3", int'(count), 3);
        check_lit("t2_done", int'(done), 1);
        check_lit("t2_state_done", int'(state), 3);
        tick();
        check_lit("t2_idle", int'(state), 0);
        check_lit("t2_done_low", int'(done), 0);
        check_lit("t2_hold", int'(count), 3);

        // bounce
        do_reset();
        mode = 2'b10; run_len = 0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_lit("t3_count", int'(count), exp_bc[i]);
            check_lit("t3_dir", int'(dir), exp_bd[i]);
        end

        // pause and resume
        do_reset();
        mode = 2'b00; run_len = 5; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check_lit("t4_c2", int'(count), 2);
        stop = 1'b1;
        tick();
        check_lit("t4_pause", int'(state), 2);
        check_lit("t4_pause_busy", int'(busy), 1);
        tick();
        check_lit("t4_hold", int'(count), 2);
        stop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_lit("t4_resume", int'(state), 1);
        check_lit("t4_resume_c", int'(count), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_lit("t4_count", int'(count), exp_p[i]);
        end
        check_lit("t4_done", int'(state), 3);
        tick();

        // start ignored with stop or hold mode
        start = 1'b1; stop = 1'b1;
        tick();
        check_lit("t5_stop_prio", int'(state), 0);
        stop = 1'b0; mode = 2'b11;
        tick();
        check_lit("t5_hold_mode", int'(state), 0);
        check_lit("t5_count", int'(count), 5);
        start = 1'b0;

        // async reset mid-run
        do_reset();
        mode = 2'b00; run_len = 0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_lit("t6_pre", int'(count), 4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_lit("t6_count", int'(count), 0);
        check_lit("t6_state", int'(state), 0);
        check_lit("t6_busy", int'(busy), 0);
        check_lit("t6_dir", int'(dir), 0);
        tick();
        reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 2) == 0);
            stop    = ($urandom_range(0, 7) == 0);
            mode    = 2'($urandom_range(0, 3));
            run_len = RUN_W'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                compare_model();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
